// File: rtl/psychic5_sound_latch_pkg.sv
// Shared types and defaults for the Psychic 5 main-to-sound command mailbox.
package psychic5_snd_pkg;
  localparam int         SNDLATCH_DEPTH_LOG2_DEF = 2;
  localparam logic [7:0] SNDLATCH_RST_CODE       = 8'h00;

  typedef logic [7:0] sndcode_t;
endpackage

// File: rtl/psychic5_sound_latch_strobe_edge.sv
// Strobe edge detector: remembers last cycle's strobe level, emits one-cycle rise/fall pulses.
module psychic5_strobe_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_n,
  input  logic act,
  output logic rise,
  output logic fall
);
  logic act_reg;

  // History keeps tracking during clear so a strobe held across clear is not re-counted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) act_reg <= 1'b0;
    else        act_reg <= act;
  end

  assign rise = clr_n &  act & ~act_reg;
  assign fall = clr_n & ~act &  act_reg;
endmodule

// File: rtl/psychic5_sound_latch.sv
// Main-to-sound command mailbox. Define PSYCHIC5_SOUNDLATCH_FIFO_EN for the
// 2^DEPTH_LOG2-entry FIFO; otherwise a single latch register like the original board.
module psychic5_sound_latch
  import psychic5_snd_pkg::*;
#(
  parameter int DEPTH_LOG2 = SNDLATCH_DEPTH_LOG2_DEF
) (
  input  logic     i_EMU_MCLK,
  input  logic     i_EMU_INITRST_n,
  input  logic     i_CLR_n,
  input  logic     i_MAIN_CS_n,
  input  logic     i_MAIN_WR_n,
  input  sndcode_t i_MAIN_DIN,
  input  logic     i_SOUND_CS_n,
  input  logic     i_SOUND_RD_n,
  output sndcode_t o_SOUNDCODE,
  output logic     o_PENDING,
  output logic     o_FULL,
  output logic     o_OVERFLOW
);
  logic wr_act, rd_act;
  logic push, pop;
  logic wr_fall_unused, rd_rise_unused;

  assign wr_act = ~i_MAIN_CS_n  & ~i_MAIN_WR_n;
  assign rd_act = ~i_SOUND_CS_n & ~i_SOUND_RD_n;

  psychic5_strobe_edge u_wr_edge (
    .clk   (i_EMU_MCLK),
    .rst_n (i_EMU_INITRST_n),
    .clr_n (i_CLR_n),
    .act   (wr_act),
    .rise  (push),
    .fall  (wr_fall_unused)
  );

  // Pop on read end so the code is stable for the whole sound CPU read.
  psychic5_strobe_edge u_rd_edge (
    .clk   (i_EMU_MCLK),
    .rst_n (i_EMU_INITRST_n),
    .clr_n (i_CLR_n),
    .act   (rd_act),
    .rise  (rd_rise_unused),
    .fall  (pop)
  );

  if (DEPTH_LOG2 < 1 || DEPTH_LOG2 > 4) begin : g_bad_depth
    $error("psychic5_sound_latch: DEPTH_LOG2 must be in 1..4");
  end

`ifdef PSYCHIC5_SOUNDLATCH_FIFO_EN
  localparam int DEPTH = 1 << DEPTH_LOG2;
  typedef logic [DEPTH_LOG2:0] ptr_t;
  localparam ptr_t PTR_ONE = 1;

  sndcode_t mem [DEPTH];
  ptr_t     wr_ptr, rd_ptr;
  sndcode_t last_code;
  logic     overflow_reg;
  logic [DEPTH_LOG2-1:0] wr_idx, rd_idx;
  logic     empty, full, pop_ok, push_ok, drop;

  assign wr_idx  = wr_ptr[DEPTH_LOG2-1:0];
  assign rd_idx  = rd_ptr[DEPTH_LOG2-1:0];
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[DEPTH_LOG2] != rd_ptr[DEPTH_LOG2]) && (wr_idx == rd_idx);
  assign pop_ok  = pop & ~empty;
  // A simultaneous pop frees a slot, so a push into a full FIFO is still accepted.
  assign push_ok = push & (~full | pop_ok);
  assign drop    = push & full & ~pop_ok;

  always_ff @(posedge i_EMU_MCLK) begin
    if (push_ok) mem[wr_idx] <= i_MAIN_DIN;
  end

  always_ff @(posedge i_EMU_MCLK or negedge i_EMU_INITRST_n) begin
    if (!i_EMU_INITRST_n) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      last_code    <= SNDLATCH_RST_CODE;
      overflow_reg <= 1'b0;
    end else if (!i_CLR_n) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      last_code    <= SNDLATCH_RST_CODE;
      overflow_reg <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop_ok) begin
        rd_ptr    <= rd_ptr + PTR_ONE;
        last_code <= mem[rd_idx];
      end
      if (drop) overflow_reg <= 1'b1;
    end
  end

  assign o_SOUNDCODE = empty ? last_code : mem[rd_idx];
  assign o_PENDING   = ~empty;
  assign o_FULL      = full;
  assign o_OVERFLOW  = overflow_reg;
`else
  sndcode_t code_reg;
  logic     pending_reg;
  logic     overflow_reg;

  always_ff @(posedge i_EMU_MCLK or negedge i_EMU_INITRST_n) begin
    if (!i_EMU_INITRST_n) begin
      code_reg     <= SNDLATCH_RST_CODE;
      pending_reg  <= 1'b0;
      overflow_reg <= 1'b0;
    end else if (!i_CLR_n) begin
      code_reg     <= SNDLATCH_RST_CODE;
      pending_reg  <= 1'b0;
      overflow_reg <= 1'b0;
    end else if (push) begin
      code_reg    <= i_MAIN_DIN;
      pending_reg <= 1'b1;
      if (pending_reg) overflow_reg <= 1'b1;
    end else if (pop) begin
      pending_reg <= 1'b0;
    end
  end

  assign o_SOUNDCODE = code_reg;
  assign o_PENDING   = pending_reg;
  assign o_FULL      = pending_reg;
  assign o_OVERFLOW  = overflow_reg;
`endif
endmodule

// File: doc/psychic5_sound_latch.md
# psychic5_sound_latch

Main-to-sound command mailbox: the main CPU writes 8-bit sound codes, and the sound CPU reads them at its sound-code window (0xE000–0xFFFF memory read). The block sits between the main CPU bus decoder and the sound board's `i_SOUNDCODE` input. It buffers bursts of commands so back-to-back writes are not lost, and it reports pending, full and overflow status. All bus strobes are sampled in the `i_EMU_MCLK` domain.

## Interface
Parameters:
- `DEPTH_LOG2`, default 2: FIFO depth is 2^DEPTH_LOG2 entries. Legal range is 1..4. Ignored when the FIFO is compiled out.

Ports (name, direction, width, meaning):
- `i_EMU_MCLK`, in, 1: the single clock for the whole block.
- `i_EMU_INITRST_n`, in, 1: reset, asynchronous and active-low.
- `i_CLR_n`, in, 1: synchronous clear, active-low. Driven from the sound CPU force-reset.
- `i_MAIN_CS_n`, in, 1: main CPU latch chip select.
- `i_MAIN_WR_n`, in, 1: main CPU write strobe.
- `i_MAIN_DIN`, in, 8: main CPU write data.
- `i_SOUND_CS_n`, in, 1: sound CPU sound-code chip select (memory space).
- `i_SOUND_RD_n`, in, 1: sound CPU read strobe.
- `o_SOUNDCODE`, out, 8: code presented to the sound CPU read mux.
- `o_PENDING`, out, 1: at least one unread code is held.
- `o_FULL`, out, 1: FIFO is full. Tied to `o_PENDING` when the FIFO is compiled out.
- `o_OVERFLOW`, out, 1: sticky flag meaning a write was dropped or a code was overwritten unread.

## Operation
Strobes:
- `wr_act = ~i_MAIN_CS_n & ~i_MAIN_WR_n`.
- `rd_act = ~i_SOUND_CS_n & ~i_SOUND_RD_n`.
- Both are registered every clock.

Push:
- A push fires on the rising edge of `wr_act`, in the first cycle where `wr_act` is 1 and the previous value was 0.
- Data is captured from `i_MAIN_DIN` in that same cycle.
- A long strobe produces exactly one push.

Pop:
- A pop fires on the falling edge of `rd_act`, i.e. when the read ends.
- The code therefore stays stable for the entire sound CPU read cycle.
- A pop while the FIFO is empty is ignored.

FIFO mode:
- When not empty, `o_SOUNDCODE` is `mem[rd_ptr]`.
- When empty, `o_SOUNDCODE` is `last_code`, the most recently popped value.
- Pointers are `DEPTH_LOG2+1` bits wide. The pointer MSB distinguishes full from empty.
- Pointers wrap modulo 2^(DEPTH_LOG2+1).

Boundary conditions:
- Push while full, with no pop in the same cycle: data is dropped, `o_OVERFLOW` is set, and the contents are unchanged.
- Push and pop in the same cycle on a non-empty FIFO: both take effect and the count is unchanged. When full, this means the push is accepted.
- Push and pop in the same cycle on an empty FIFO: the push takes effect and the pop is ignored. Emptiness is evaluated at the start of the cycle.

Clearing:
- `i_CLR_n` low empties the FIFO, sets `last_code` to 8'h00, and clears `o_OVERFLOW`.
- `i_CLR_n` has priority over push and pop in the same cycle.
- A strobe edge whose edge cycle falls while `i_CLR_n` is low is discarded.

Reset:
- Asynchronous reset does the same as clear.
- It also zeroes both pointers and both strobe history registers.

Reset values of the outputs:
- `o_SOUNDCODE` = 8'h00
- `o_PENDING` = 0
- `o_FULL` = 0
- `o_OVERFLOW` = 0

## Timing
- The edge-detect cycle is cycle N.
- The storage update is registered at the end of cycle N.
- For a push into an empty FIFO, `o_SOUNDCODE`, `o_PENDING` and `o_FULL` reflect the push from cycle N+1.
- After a pop, the next code (or `last_code`) is presented from cycle N+1.
- `o_SOUNDCODE`, `o_PENDING` and `o_FULL` are combinational from state registers only, with no input-to-output path.
- `o_OVERFLOW` is registered.
- Strobes must be low or high for at least 1 MCLK. They are synchronous to MCLK because they come from CEN-gated T80 cores.

## Configuration
`PSYCHIC5_SOUNDLATCH_FIFO_EN`:
- Defined: the 2^DEPTH_LOG2-entry FIFO described above.
- Undefined: a single 8-bit register, matching the original hardware latch.
  - A push always overwrites and sets `o_PENDING`.
  - A push while `o_PENDING` is set also sets `o_OVERFLOW`.
  - A pop clears `o_PENDING`. The register keeps its value.
  - `o_SOUNDCODE` is the register.
  - A push and pop in the same cycle leave `o_PENDING` set.

## Structure
Package `psychic5_snd_pkg` holds:
- `SNDLATCH_DEPTH_LOG2_DEF` = 2
- `SNDLATCH_RST_CODE` = 8'h00
- typedef `sndcode_t` = logic [7:0]

Sub-module `psychic5_strobe_edge`:
- Registered active-level strobe in, rise and fall pulses out.
- Asynchronous reset, synchronous clear.
- Instantiated twice.

## Test plan
1. Reset, then a write of 8'h2A with a 5-cycle strobe: exactly one push, `o_SOUNDCODE`=8'h2A and `o_PENDING`=1 at edge+1.
2. FIFO mode, DEPTH_LOG2=2: write 8'h01–8'h05 with no reads. Expect `o_FULL`=1 after 8'h04, 8'h05 dropped, `o_OVERFLOW`=1. Four reads then return 8'h01–8'h04, and the output holds 8'h04 when empty.
3. While full, a write of 8'h10 with its edge cycle equal to the read-end cycle: the pop is accepted and the push is accepted. The remaining order is 8'h02, 8'h03, 8'h04, 8'h10, and `o_OVERFLOW` is unchanged.
4. Read strobe on an empty FIFO after reset: `o_SOUNDCODE` stays 8'h00, `o_PENDING`=0, and the pointers are unchanged.
5. Pulse `i_CLR_n` low with 3 entries held: `o_PENDING`=0, `o_SOUNDCODE`=8'h00, `o_OVERFLOW`=0 on the next cycle. Assert async reset mid-write: outputs clear immediately.
6. Macro undefined: write 8'hA0, then 8'hA1 with no read. `o_SOUNDCODE`=8'hA1, `o_OVERFLOW`=1. After a read, `o_PENDING`=0 and `o_SOUNDCODE`=8'hA1.
